// File: rtl/rsr_reg.sv
// UART receive shift register: synchronises rx_in, deserialises one character per
// frame using the oversampling tick, checks parity/stop and strobes it into the RBR FIFO.
module rsr_reg #(
    parameter int OSR         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stick,
    input  logic       rx_in,
    input  logic [1:0] tlen,
    input  logic       parity_en,
    input  logic       parity_type,
    input  logic       fifo_full,
    output logic       wr_en,
    output logic [7:0] rdata,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       break_det,
    output logic       rx_busy
);

    localparam int TW = $clog2(OSR);
    localparam logic [TW-1:0] MID_CNT  = TW'(OSR / 2 - 1);
    localparam logic [TW-1:0] FULL_CNT = TW'(OSR - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WRITE     = 3'd5,
        WAIT_HIGH = 3'd6
    } state_t;

    function automatic logic calc_parity(input logic [7:0] d);
        return ^d;
    endfunction

    state_t          state_r, state_nxt;
    logic [SYNC_STAGES-1:0] sync_r;
    logic [TW-1:0]   tick_cnt_r;
    logic [3:0]      bit_cnt_r;
    logic [7:0]      shreg_r;
    logic            pbit_r, stop_ok_r;
    logic [1:0]      tlen_r;
    logic            par_en_r;

    logic            wr_en_r, parity_err_r, frame_err_r, overrun_err_r, break_det_r, rx_busy_r;
    logic [7:0]      rdata_r;
    logic            wr_en_s, parity_err_s, frame_err_s, overrun_err_s, break_det_s, rx_busy_s;
    logic [7:0]      rdata_s;

    logic            rx_s, counting_s, mid_hit_s, bit_hit_s, wr_go_s;
    logic [3:0]      nbits_s;
    logic [7:0]      data_s;

    assign rx_s       = sync_r[SYNC_STAGES-1];
    assign counting_s = (state_r == START) || (state_r == DATA) ||
                        (state_r == PARITY) || (state_r == STOP);
    assign mid_hit_s  = stick && (tick_cnt_r == MID_CNT);
    assign bit_hit_s  = stick && (tick_cnt_r == FULL_CNT);
    assign nbits_s    = {2'b00, tlen_r} + 4'd5;
    // Data bits enter at shreg[7], so after N shifts the character sits in the top N bits.
    assign data_s     = shreg_r >> (4'd8 - nbits_s);
    // Outputs are registered off the stop-bit sample so they appear during the WRITE clk.
    assign wr_go_s    = (state_r == STOP) && bit_hit_s;

    // rx_in synchroniser, preset to the idle (high) line level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= '1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], rx_in};
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE: begin
                if (stick && !rx_s) state_nxt = START;
                else                state_nxt = IDLE;
            end
            START: begin
                if (mid_hit_s) state_nxt = rx_s ? IDLE : DATA;
                else           state_nxt = START;
            end
            DATA: begin
                if (bit_hit_s && (bit_cnt_r == nbits_s - 4'd1)) state_nxt = par_en_r ? PARITY : STOP;
                else                                            state_nxt = DATA;
            end
            PARITY: begin
                if (bit_hit_s) state_nxt = STOP;
                else           state_nxt = PARITY;
            end
            STOP: begin
                if (bit_hit_s) state_nxt = WRITE;
                else           state_nxt = STOP;
            end
            WRITE: begin
                if (stop_ok_r) state_nxt = IDLE;
                else           state_nxt = WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (stick && rx_s) state_nxt = IDLE;
                else               state_nxt = WAIT_HIGH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM output logic: next values of the registered outputs
    always_comb begin
        wr_en_s       = 1'b0;
        overrun_err_s = 1'b0;
        frame_err_s   = 1'b0;
        parity_err_s  = 1'b0;
        break_det_s   = 1'b0;
        rdata_s       = rdata_r;
        if (wr_go_s) begin
            wr_en_s       = !fifo_full;
            overrun_err_s = fifo_full;
            frame_err_s   = !rx_s;
            parity_err_s  = par_en_r && (pbit_r != (calc_parity(data_s) ^ parity_type));
            break_det_s   = (data_s == 8'd0) && (!par_en_r || !pbit_r) && !rx_s;
            rdata_s       = data_s;
        end else begin
            rdata_s       = rdata_r;
        end
        rx_busy_s = (state_nxt != IDLE);
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_r       <= 1'b0;
            overrun_err_r <= 1'b0;
            frame_err_r   <= 1'b0;
            parity_err_r  <= 1'b0;
            break_det_r   <= 1'b0;
            rdata_r       <= 8'd0;
            rx_busy_r     <= 1'b0;
        end else begin
            wr_en_r       <= wr_en_s;
            overrun_err_r <= overrun_err_s;
            frame_err_r   <= frame_err_s;
            parity_err_r  <= parity_err_s;
            break_det_r   <= break_det_s;
            rdata_r       <= rdata_s;
            rx_busy_r     <= rx_busy_s;
        end
    end

    // Tick/bit counters, shift register, captured bits and per-frame config
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_r <= '0;
            bit_cnt_r  <= 4'd0;
            shreg_r    <= 8'd0;
            pbit_r     <= 1'b0;
            stop_ok_r  <= 1'b0;
            tlen_r     <= 2'b00;
            par_en_r   <= 1'b0;
        end else begin
            if (state_nxt != state_r)          tick_cnt_r <= '0;
            else if (counting_s && bit_hit_s)  tick_cnt_r <= '0;
            else if (counting_s && stick)      tick_cnt_r <= tick_cnt_r + {{(TW-1){1'b0}}, 1'b1};
            else                               tick_cnt_r <= tick_cnt_r;

            if ((state_r == START) && (state_nxt == DATA)) bit_cnt_r <= 4'd0;
            else if ((state_r == DATA) && bit_hit_s)       bit_cnt_r <= bit_cnt_r + 4'd1;
            else                                           bit_cnt_r <= bit_cnt_r;

            if ((state_r == DATA) && bit_hit_s) shreg_r <= {rx_s, shreg_r[7:1]};
            else                                shreg_r <= shreg_r;

            if ((state_r == PARITY) && bit_hit_s) pbit_r <= rx_s;
            else                                  pbit_r <= pbit_r;

            if (wr_go_s) stop_ok_r <= rx_s;
            else         stop_ok_r <= stop_ok_r;

            if ((state_r == IDLE) && (state_nxt == START)) begin
                tlen_r   <= tlen;
                par_en_r <= parity_en;
            end else begin
                tlen_r   <= tlen_r;
                par_en_r <= par_en_r;
            end
        end
    end

    assign wr_en       = wr_en_r;
    assign rdata       = rdata_r;
    assign parity_err  = parity_err_r;
    assign frame_err   = frame_err_r;
    assign overrun_err = overrun_err_r;
    assign break_det   = break_det_r;
    assign rx_busy     = rx_busy_r;

endmodule

// File: tb/tb_rsr_reg.sv
// Self-checking bench for rsr_reg: directed frames from the test plan plus random frames
// checked against an arithmetic frame model.
module tb_rsr_reg;

    localparam int OSR      = 16;
    localparam int BIT_CLKS = OSR * 2;

    logic       clk = 1'b0;
    logic       rst, stick, rx_in, parity_en, parity_type, fifo_full;
    logic [1:0] tlen;
    logic       wr_en, parity_err, frame_err, overrun_err, break_det, rx_busy;
    logic [7:0] rdata;

    int total = 0;
    int bad   = 0;
    int n_wr = 0, n_par = 0, n_frm = 0, n_ovr = 0, n_brk = 0, n_stray = 0;

    rsr_reg #(.OSR(OSR), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .stick(stick), .rx_in(rx_in), .tlen(tlen),
        .parity_en(parity_en), .parity_type(parity_type), .fifo_full(fifo_full),
        .wr_en(wr_en), .rdata(rdata), .parity_err(parity_err), .frame_err(frame_err),
        .overrun_err(overrun_err), .break_det(break_det), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    // Oversampling tick: one clk high every two clks
    initial begin
        stick = 1'b0;
        forever begin
            @(negedge clk);
            stick = ~stick;
        end
    end

    // Pulse counters; error pulses outside a write/overrun cycle count as stray
    always @(negedge clk) begin
        if (wr_en)       n_wr  <= n_wr + 1;
        if (parity_err)  n_par <= n_par + 1;
        if (frame_err)   n_frm <= n_frm + 1;
        if (overrun_err) n_ovr <= n_ovr + 1;
        if (break_det)   n_brk <= n_brk + 1;
        if ((parity_err || frame_err || break_det) && !(wr_en || overrun_err))
            n_stray <= n_stray + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    // Sends one frame and checks every pulse and rdata against the frame model
    task automatic run_frame(input string tag, input logic [7:0] d, input logic [1:0] tl,
                             input logic pe, input logic pt, input logic pb,
                             input logic stp, input logic ff);
        int         n;
        int         w0, p0, f0, o0, b0, s0;
        logic [7:0] mask, dm;
        logic       exp_pbit, exp_perr, exp_brk;
        n        = int'(tl) + 5;
        mask     = 8'((1 << n) - 1);
        dm       = d & mask;
        exp_pbit = (($countones(dm) % 2) == 1) ^ pt;
        exp_perr = pe && (pb != exp_pbit);
        exp_brk  = (dm == 8'd0) && (!pe || !pb) && !stp;
        w0 = n_wr; p0 = n_par; f0 = n_frm; o0 = n_ovr; b0 = n_brk; s0 = n_stray;
        tlen = tl; parity_en = pe; parity_type = pt; fifo_full = ff;
        @(negedge clk);
        rx_in = 1'b0;
        repeat (BIT_CLKS / 2) @(negedge clk);
        // Config is latched at frame start; scrambling it now must not matter
        tlen = 2'($urandom); parity_en = 1'($urandom);
        repeat (BIT_CLKS / 2) @(negedge clk);
        for (int i = 0; i < n; i++) drive_bit(d[i]);
        if (pe) drive_bit(pb);
        drive_bit(stp);
        if (!stp) begin
            repeat (BIT_CLKS / 2) @(negedge clk);
            chk({tag, ":busy_wait_high"}, 32'(rx_busy), 32'd1);
            rx_in = 1'b1;
        end
        repeat (10) @(negedge clk);
        chk({tag, ":wr_en"},   32'(n_wr - w0),    ff ? 32'd0 : 32'd1);
        chk({tag, ":overrun"}, 32'(n_ovr - o0),   ff ? 32'd1 : 32'd0);
        chk({tag, ":par_err"}, 32'(n_par - p0),   32'(exp_perr));
        chk({tag, ":frm_err"}, 32'(n_frm - f0),   32'(!stp));
        chk({tag, ":break"},   32'(n_brk - b0),   32'(exp_brk));
        chk({tag, ":stray"},   32'(n_stray - s0), 32'd0);
        chk({tag, ":rdata"},   32'(rdata),        32'(dm));
        chk({tag, ":idle"},    32'(rx_busy),      32'd0);
        fifo_full = 1'b0;
    endtask

    initial begin
        int w0, f0, b0, p0;
        rst = 1'b1; rx_in = 1'b1; tlen = 2'b11; parity_en = 1'b0;
        parity_type = 1'b0; fifo_full = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset:outs", {24'd0, wr_en, parity_err, frame_err, overrun_err, break_det, rx_busy, 2'b00}, 32'd0);
        chk("reset:rdata", 32'(rdata), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        run_frame("8n1_a5",   8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_frame("5o_good",  8'h13, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        run_frame("5o_bad",   8'h13, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

        // Glitch: 4 ticks low then high must not start a frame
        w0 = n_wr; f0 = n_frm;
        rx_in = 1'b0;
        repeat (8) @(negedge clk);
        rx_in = 1'b1;
        repeat (BIT_CLKS + 8) @(negedge clk);
        chk("glitch:wr_en", 32'(n_wr - w0), 32'd0);
        chk("glitch:frm",   32'(n_frm - f0), 32'd0);
        chk("glitch:idle",  32'(rx_busy), 32'd0);
        run_frame("after_glitch", 8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        run_frame("frame_err", 8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Break: line low for two frame times gives exactly one break/frame pulse
        w0 = n_wr; f0 = n_frm; b0 = n_brk; p0 = n_par;
        tlen = 2'b11; parity_en = 1'b0;
        rx_in = 1'b0;
        repeat (20 * BIT_CLKS) @(negedge clk);
        chk("break:busy_low", 32'(rx_busy), 32'd1);
        rx_in = 1'b1;
        repeat (3 * BIT_CLKS) @(negedge clk);
        chk("break:wr_en", 32'(n_wr - w0),  32'd1);
        chk("break:frm",   32'(n_frm - f0), 32'd1);
        chk("break:brk",   32'(n_brk - b0), 32'd1);
        chk("break:par",   32'(n_par - p0), 32'd0);
        chk("break:rdata", 32'(rdata), 32'd0);
        chk("break:idle",  32'(rx_busy), 32'd0);

        run_frame("overrun",   8'h7E, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        run_frame("after_ovr", 8'h81, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset during data bit 3 of 0xC3
        w0 = n_wr;
        tlen = 2'b11; parity_en = 1'b0;
        drive_bit(1'b0);
        drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b0);
        rx_in = 1'b0;
        repeat (BIT_CLKS / 2) @(negedge clk);
        chk("rst_mid:busy_before", 32'(rx_busy), 32'd1);
        rst = 1'b1; rx_in = 1'b1;
        @(negedge clk);
        chk("rst_mid:outs", {24'd0, wr_en, parity_err, frame_err, overrun_err, break_det, rx_busy, 2'b00}, 32'd0);
        chk("rst_mid:rdata", 32'(rdata), 32'd0);
        rst = 1'b0;
        repeat (3 * BIT_CLKS) @(negedge clk);
        chk("rst_mid:no_wr", 32'(n_wr - w0), 32'd0);
        run_frame("after_rst", 8'hC3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        for (int k = 0; k < 12; k++) begin
            run_frame("rand", 8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
